// File: rtl/ad7643_slave_emu_if.sv
// ad7643_slave_emu_if: CNVST/BUSY/CS/SCLK/SDOUT link between the acquisition controller and the emulated ADC.
interface ad7643_slave_emu_if #(
    parameter int DATA_W = 18
);
    logic              cnvst;
    logic              cs;
    logic              sclk;
    logic              sample_sel;
    logic [DATA_W-1:0] sample_in;
    logic              busy;
    logic              sdout;
    logic              rderr;
    logic [15:0]       conv_cnt;

    modport master (
        output cnvst, cs, sclk, sample_sel, sample_in,
        input  busy, sdout, rderr, conv_cnt
    );

    modport slave (
        input  cnvst, cs, sclk, sample_sel, sample_in,
        output busy, sdout, rderr, conv_cnt
    );
endinterface

// File: rtl/ad7643_slave_emu.sv
// ad7643_slave_emu: AD7643 serial-slave ADC emulator; answers CNVST with a BUSY pulse and shifts a sample out MSB-first on SCLK.
module ad7643_slave_emu #(
    parameter int DATA_W      = 18,
    parameter int BUSY_CYCLES = 160
) (
    input logic               clk,
    input logic               rst,
    ad7643_slave_emu_if.slave bus
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int CW = $clog2(BUSY_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, READ = 2'd2;

    logic [1:0]        state;
    logic [2:0]        cnvst_s, cs_s, sclk_s;
    logic [DATA_W-1:0] sample, sh, ramp;
    logic [BW-1:0]     bits;
    logic [CW-1:0]     bcnt;
    logic [15:0]       conv_cnt;
    logic              busy, rderr;
    logic              cnvst_rise, sclk_fall, cs_low;

    // bit [1] is the synchronized level, bit [2] the edge-detect history
    assign cnvst_rise = cnvst_s[1] & ~cnvst_s[2];
    assign sclk_fall  = ~sclk_s[1] & sclk_s[2];
    assign cs_low     = ~cs_s[1];

    assign bus.busy     = busy;
    assign bus.sdout    = cs_low & sh[DATA_W-1];
    assign bus.rderr    = rderr;
    assign bus.conv_cnt = conv_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnvst_s  <= '0;
            cs_s     <= '1;
            sclk_s   <= '0;
            sample   <= '0;
            sh       <= '0;
            ramp     <= '0;
            bits     <= '0;
            bcnt     <= '0;
            conv_cnt <= '0;
            busy     <= 1'b0;
            rderr    <= 1'b0;
        end else begin
            cnvst_s <= {cnvst_s[1:0], bus.cnvst};
            cs_s    <= {cs_s[1:0], bus.cs};
            sclk_s  <= {sclk_s[1:0], bus.sclk};
            // a start in READ wins over a coincident SCLK fall; the shift is dropped
            if (cnvst_rise && state != CONV) begin
                state    <= CONV;
                sample   <= bus.sample_sel ? bus.sample_in : ramp;
                busy     <= 1'b1;
                bcnt     <= '0;
                conv_cnt <= conv_cnt + 16'd1;
                ramp     <= ramp + 1'b1;
                rderr    <= state == READ && bits != BW'(DATA_W);
            end else if (state == CONV) begin
                if (bcnt == CW'(BUSY_CYCLES - 1)) begin
                    state <= READ;
                    sh    <= sample;
                    bits  <= '0;
                    busy  <= 1'b0;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end else if (state == READ && sclk_fall && cs_low && bits != BW'(DATA_W)) begin
                sh   <= sh << 1;
                bits <= bits + 1'b1;
            end
        end
    end
endmodule

// File: doc/ad7643_slave_emu.md
# ad7643_slave_emu

Synthesizable emulator of the AD7643 serial-slave-mode ADC, i.e. the converter side of the CNVST/BUSY/CS/SCLK/SDOUT link the MAX10 controller drives. It answers conversion starts with a BUSY pulse and shifts an 18-bit sample out MSB-first on SCLK. It sits on the digital port in place of a physical ADC, or as a loopback target, so the acquisition, dmem storage and FT600 readout paths can be checked with known data.

## Interface
- DATA_W, 18, sample width and number of bits per readout
- BUSY_CYCLES, 160, CLK cycles ADBUSY stays high per conversion (≈1.3 µs at 8 ns)
- CLK  in  1  system clock; all logic on posedge
- RST  in  1  asynchronous, active-high reset
- ADCNVST  in  1  conversion start; rising edge starts a conversion
- ADCS  in  1  chip select, active low; enables readout
- ADSCLK  in  1  serial clock from controller
- SAMPLE_SEL  in  1  0 = internal ramp, 1 = SAMPLE_IN
- SAMPLE_IN  in  DATA_W  external sample value
- ADBUSY  out  1  high while converting
- ADSDOUT  out  1  serial data, MSB first
- ADRDERR  out  1  sticky read-error flag
- CONV_CNT  out  16  accepted conversions, wraps

## Operation
- ADCNVST, ADCS and ADSCLK pass through 2-flop synchronizers, then 1-flop edge detectors; only synchronized values are used.
- States: IDLE, CONV, READ.
- IDLE/READ + CNVST rise → CONV. On entry: latch sample (ramp if SAMPLE_SEL=0, else SAMPLE_IN), ADBUSY=1, busy counter=0, CONV_CNT+1 (wrap 0xFFFF→0), ramp+1 (wrap 2^DATA_W−1→0; the ramp advances even when SAMPLE_SEL=1).
- ADRDERR: on accepted CNVST rise from READ with bit count < DATA_W → set; on one with bit count = DATA_W, or from IDLE → cleared. Cleared only by RST or such a clean start.
- CONV: CNVST rises are ignored (no restart, no counter change). After BUSY_CYCLES cycles: shift register ← latched sample, bit count=0, ADBUSY=0, → READ.
- READ: while sync CS low, each sync SCLK falling edge shifts left by 1 and fills 0 into the LSB. Bit count increments, saturating at DATA_W. Once DATA_W shifts are done, ADSDOUT=0.
- CS high: shift register and bit count hold; SCLK edges are ignored.
- ADSDOUT = shift-register MSB when sync CS low, else 0.
- SCLK falling edges in IDLE or CONV: ignored.
- RST mid-conversion or mid-readout: immediate return to IDLE with all reset values; the pending sample is discarded.

## Timing
- Reset values: ADBUSY=0, ADSDOUT=0, ADRDERR=0, CONV_CNT=0, ramp=0, shift register=0, state IDLE.
- CNVST pin rise → ADBUSY high: 3 CLK edges (2 sync + 1 edge detect register).
- ADBUSY high for exactly BUSY_CYCLES CLK cycles.
- ADBUSY fall cycle: the MSB appears on ADSDOUT in that same cycle if CS is already low. Otherwise it appears 2 CLK after CS pin falls.
- SCLK pin fall → ADSDOUT update: 3 CLK. The controller samples ADSDOUT on or before the next SCLK rise.
- Required controller pacing: SCLK high and low phases ≥ 4 CLK each; CNVST high ≥ 3 CLK. Faster edges are not guaranteed to be seen.
- Simultaneous CNVST rise and SCLK fall in READ: the conversion start wins. ADRDERR is evaluated on the bit count before that edge, and the shift is dropped.

## Test plan
- Reset, SAMPLE_SEL=0, CNVST pulse → ADBUSY high 3 CLK later for 160 cycles; then 18 SCLK with CS low read 0x00000 and CONV_CNT=1. Second conversion reads 0x00001.
- SAMPLE_SEL=1, SAMPLE_IN=0x2A5C3, full 18-clock read → bits 1,0,1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. A 19th SCLK reads 0.
- CNVST pulse 50 cycles into CONV → ignored: ADBUSY still falls 160 cycles after the first start, CONV_CNT increments only once.
- Read 10 bits, then CNVST → ADRDERR=1 and the new sample loads. Full 18-bit read, then CNVST → ADRDERR=0.
- Force ramp to 0x3FFFF → converted value 0x3FFFF, next conversion 0x00000. 65536 conversions → CONV_CNT wraps to 0.
- Assert RST during CONV, and again after 5 shifted bits → all outputs at reset values next cycle. A following conversion reads ramp value 0.
